// File: rtl/core_pipe_datapath.sv
`default_nettype none
// ============================================================================
// Module      : core_pipe_datapath
// Description : Three-stage RV32 integer datapath.
//               ID : register file read (with WB bypass), immediate generation
//               EX : ALU, data-memory request, branch resolution
//               WB : register file write
//               Control decode is external. Only the current instruction is
//               presented; this block steers the PC.
// Ports       : clk          - rising-edge clock
//               reset        - asynchronous, active-low reset
//               instruction  - instruction at PC (ID stage)
//               branch, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite,
//               control[3:0] - decoded controls for instruction
//               mem_rdata    - load data
//               mem_ready    - data memory completes the access this cycle
//               PC           - fetch address
//               address      - EX-stage ALU result
//               wdata        - EX-stage store data
//               mem_rd/mem_wr- EX-stage valid load/store request
// Config      : define CORE_PIPE_FWD_EN to forward EX/WB results into EX
//               operands; otherwise a one-cycle load-use/RAW interlock is used.
// Revision    : 1.0 - initial release
// ============================================================================
module core_pipe_datapath #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [31:0]     instruction,
    input  wire logic            branch,
    input  wire logic            RegWrite,
    input  wire logic            ALUSrc,
    input  wire logic            MemtoReg,
    input  wire logic            MemRead,
    input  wire logic            MemWrite,
    input  wire logic [3:0]      control,
    input  wire logic [XLEN-1:0] mem_rdata,
    input  wire logic            mem_ready,
    output logic [XLEN-1:0]      PC,
    output logic [XLEN-1:0]      address,
    output logic [XLEN-1:0]      wdata,
    output logic                 mem_rd,
    output logic                 mem_wr
);

    localparam int         c_ridx_w  = $clog2(NREG);
    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [6:0] c_op_load = 7'b0000011;
    localparam logic [6:0] c_op_imm  = 7'b0010011;
    localparam logic [6:0] c_op_st   = 7'b0100011;
    localparam logic [6:0] c_op_br   = 7'b1100011;

    // ------------------------------------------------------------------ state
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_regs [NREG];

    logic                r_ex_valid;
    logic [XLEN-1:0]     r_ex_pc, r_ex_a, r_ex_b, r_ex_imm;
    logic [c_ridx_w-1:0] r_ex_rd;
    logic                r_ex_branch, r_ex_regwrite, r_ex_alusrc;
    logic                r_ex_memtoreg, r_ex_memread, r_ex_memwrite;
    logic [3:0]          r_ex_ctrl;

    logic                r_wb_valid, r_wb_regwrite;
    logic [c_ridx_w-1:0] r_wb_rd;
    logic [XLEN-1:0]     r_wb_data;

    // --------------------------------------------------------------- ID stage
    logic [c_ridx_w-1:0] w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]     w_imm, w_rs1_val, w_rs2_val;
    logic                w_wb_we;
    logic                w_unused_funct3;

    assign w_rs1           = instruction[15 +: c_ridx_w];
    assign w_rs2           = instruction[20 +: c_ridx_w];
    assign w_rd            = instruction[7  +: c_ridx_w];
    assign w_unused_funct3 = ^instruction[14:12];
    assign w_wb_we         = r_wb_valid & r_wb_regwrite & (r_wb_rd != '0);

    always_comb begin
        w_imm = '0;
        case (instruction[6:0])
            c_op_load, c_op_imm:
                w_imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            c_op_st:
                w_imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
            c_op_br:
                w_imm = {{(XLEN-12){instruction[31]}}, instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Same-cycle WB write is visible to ID reads (write-through bypass).
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != '0)
            w_rs1_val = (w_wb_we && r_wb_rd == w_rs1) ? r_wb_data : r_regs[w_rs1];
        if (w_rs2 != '0)
            w_rs2_val = (w_wb_we && r_wb_rd == w_rs2) ? r_wb_data : r_regs[w_rs2];
    end

    // --------------------------------------------------------------- EX stage
    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu, w_target;
    logic            w_zero, w_taken, w_stall, w_hazard;

`ifdef CORE_PIPE_FWD_EN
    logic [c_ridx_w-1:0] r_ex_rs1, r_ex_rs2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
        end else if (!w_stall) begin
            r_ex_rs1 <= w_rs1;
            r_ex_rs2 <= w_rs2;
        end
    end

    assign w_fwd_a  = (w_wb_we && r_wb_rd == r_ex_rs1) ? r_wb_data : r_ex_a;
    assign w_fwd_b  = (w_wb_we && r_wb_rd == r_ex_rs2) ? r_wb_data : r_ex_b;
    assign w_hazard = 1'b0;
`else
    logic w_use_rs2;

    assign w_fwd_a   = r_ex_a;
    assign w_fwd_b   = r_ex_b;
    assign w_use_rs2 = !ALUSrc | MemWrite;
    // ID consumes a register the EX instruction is about to write.
    assign w_hazard  = r_ex_valid & r_ex_regwrite & (r_ex_rd != '0) &
                       ((r_ex_rd == w_rs1) | (w_use_rs2 & (r_ex_rd == w_rs2)));
`endif

    assign w_alu_b = r_ex_alusrc ? r_ex_imm : w_fwd_b;

    always_comb begin
        w_alu = '0;
        case (r_ex_ctrl)
            c_alu_and: w_alu = w_fwd_a & w_alu_b;
            c_alu_or:  w_alu = w_fwd_a | w_alu_b;
            c_alu_add: w_alu = w_fwd_a + w_alu_b;
            c_alu_sub: w_alu = w_fwd_a - w_alu_b;
            c_alu_slt: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_alu_b))};
            default:   w_alu = '0;
        endcase
    end

    assign w_zero   = (w_alu == '0);
    assign w_target = r_ex_pc + r_ex_imm;
    assign w_taken  = r_ex_valid & r_ex_branch & w_zero;
    assign mem_rd   = r_ex_valid & r_ex_memread;
    assign mem_wr   = r_ex_valid & r_ex_memwrite;
    assign w_stall  = (mem_rd | mem_wr) & !mem_ready;
    assign address  = r_ex_valid ? w_alu   : '0;
    assign wdata    = r_ex_valid ? w_fwd_b : '0;
    assign PC       = r_pc;

    // ------------------------------------------------------ pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= PC_RESET;
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_a        <= '0;
            r_ex_b        <= '0;
            r_ex_imm      <= '0;
            r_ex_rd       <= '0;
            r_ex_branch   <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_ctrl     <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
        end else begin
            r_wb_valid    <= r_ex_valid & !w_stall;
            r_wb_regwrite <= r_ex_regwrite;
            r_wb_rd       <= r_ex_rd;
            r_wb_data     <= (r_ex_memtoreg & mem_ready) ? mem_rdata : w_alu;

            if (w_stall) begin
                // Held entry keeps the forwarded operands: the producer leaves
                // EX/WB while this entry waits.
                r_ex_a <= w_fwd_a;
                r_ex_b <= w_fwd_b;
            end else begin
                if (w_taken)
                    r_pc <= w_target;
                else if (!w_hazard)
                    r_pc <= r_pc + XLEN'(4);
                // Taken branch squashes the instruction fetched behind it;
                // an interlock re-presents the same ID instruction next cycle.
                r_ex_valid    <= !w_taken & !w_hazard;
                r_ex_pc       <= r_pc;
                r_ex_a        <= w_rs1_val;
                r_ex_b        <= w_rs2_val;
                r_ex_imm      <= w_imm;
                r_ex_rd       <= w_rd;
                r_ex_branch   <= branch;
                r_ex_regwrite <= RegWrite;
                r_ex_alusrc   <= ALUSrc;
                r_ex_memtoreg <= MemtoReg;
                r_ex_memread  <= MemRead;
                r_ex_memwrite <= MemWrite;
                r_ex_ctrl     <= control;
            end
        end
    end

    // ----------------------------------------------------------- register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_wb_we) begin
            r_regs[r_wb_rd] <= r_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/core_pipe_datapath.md
CORE_PIPE_DATAPATH -- requirements
Module: core_pipe_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/register/PC width (>=32).
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count (power of 2, <=32).
REQ-003 SHALL have parameter PC_RESET, default 0, meaning PC value after reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port instruction  input  32  RV32 instruction for current PC (ID stage).
REQ-007 SHALL have ports branch, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite  input  1 each  decoded controls for instruction.
REQ-008 SHALL have port control  input  4  ALU op for instruction.
REQ-009 SHALL have port mem_rdata  input  XLEN  load data.
REQ-010 SHALL have port mem_ready  input  1  data memory completes access this cycle.
REQ-011 SHALL have port PC  output  XLEN  fetch address.
REQ-012 SHALL have ports address, wdata  output  XLEN  EX-stage ALU result / store data.
REQ-013 SHALL have ports mem_rd, mem_wr  output  1  EX-stage valid load/store request.

Function
REQ-014 SHALL be a 3-stage pipeline: ID (regfile read, immediate gen, into ID/EX register), EX (ALU, memory, branch resolve, into EX/WB register), WB (regfile write).
REQ-015 SHALL generate immediates by opcode: I-type (0000011, 0010011), S-type (0100011), B-type (1100011), sign-extended to XLEN; others 0.
REQ-016 SHALL implement ALU ops control 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 signed SLT, other codes result 0; zero = (result==0).
REQ-017 SHALL take branch when EX valid & branch & zero; target = PC-of-instruction + B-immediate, modulo 2^XLEN.
REQ-018 SHALL on taken branch load PC with target and invalidate the ID/EX entry captured that edge (exactly 1 bubble); otherwise PC += 4.
REQ-019 SHALL keep register 0 reading 0; writes to it discarded.
REQ-020 SHALL bypass WB write data to same-cycle ID reads of the same register.
REQ-021 SHALL assert mem_rd/mem_wr only while EX entry valid; stall when (mem_rd|mem_wr) & !mem_ready: PC, ID/EX hold, EX/WB loads bubble.
REQ-022 SHALL capture mem_rdata into EX/WB when MemtoReg & mem_ready; otherwise ALU result.
REQ-023 SHALL give taken branch priority over nothing else: a branch never coexists with a memory stall (branches issue no request).
REQ-024 SHALL use register indices modulo NREG (low log2(NREG) bits).

Reset
REQ-025 SHALL on reset low set PC=PC_RESET, clear all registers to 0, clear ID/EX and EX/WB valid bits; address, wdata = 0, mem_rd = mem_wr = 0.
REQ-026 SHALL abort any in-flight access on reset assertion mid-stall; first fetch at PC_RESET on first edge after release.

Configuration
REQ-027 SHALL, with macro CORE_PIPE_FWD_EN defined, forward EX/WB result to EX operands on rd match (rd!=0, RegWrite), zero stalls for back-to-back dependencies.
REQ-028 SHALL, without CORE_PIPE_FWD_EN, interlock: when ID reads rd of valid EX-stage RegWrite instruction, hold PC/ID one cycle and inject EX bubble.

Verification
REQ-029 SHALL pass: reset low mid-run -> PC=0, mem_rd=0 immediately; after release PC sequence 0,4,8.
REQ-030 SHALL pass: addi x1,x0,5; addi x2,x1,3 back-to-back -> x2=8; with FWD_EN 0 stall cycles, without it 1.
REQ-031 SHALL pass: beq x0,x0,+16 at PC 8 -> next PCs 12 then 24; instruction at 12 never writes register.
REQ-032 SHALL pass: lw with mem_ready low 3 cycles, mem_rdata=0xDEADBEEF -> PC frozen 3 cycles, rd=0xDEADBEEF, no duplicate write.
REQ-033 SHALL pass: addi x0,x0,7 -> x0 reads 0; SLT of -1 vs 1 -> 1.
REQ-034 SHALL pass: PC at 0xFFFFFFFC (XLEN=32) -> wraps to 0.
